// File: rtl/strength_resolver_reg_pkg.sv
// Shared value/strength encodings and helpers for the strength resolver.
// Strength codes are ordered so that a numeric compare gives drive dominance.
package strength_pkg;

    typedef enum logic [1:0] {
        V0 = 2'b00,
        V1 = 2'b01,
        VX = 2'b10,
        VZ = 2'b11
    } val_e;

    localparam int STR_W = 3;

    localparam logic [STR_W-1:0] STR_HIGHZ  = 3'd0;
    localparam logic [STR_W-1:0] STR_SMALL  = 3'd1;
    localparam logic [STR_W-1:0] STR_MEDIUM = 3'd2;
    localparam logic [STR_W-1:0] STR_WEAK   = 3'd3;
    localparam logic [STR_W-1:0] STR_LARGE  = 3'd4;
    localparam logic [STR_W-1:0] STR_PULL   = 3'd5;
    localparam logic [STR_W-1:0] STR_STRONG = 3'd6;
    localparam logic [STR_W-1:0] STR_SUPPLY = 3'd7;

    function automatic logic [STR_W-1:0] max_str(input logic [STR_W-1:0] a,
                                                 input logic [STR_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/strength_resolver_reg_bit.sv
// Combinational resolution of one net bit from N_DRV strength-qualified drivers.
// Reports the winning value/strength plus undriven and equal-strength 0/1 conflict flags.
module strength_bit_resolver
    import strength_pkg::*;
#(
    parameter int N_DRV = 4
) (
    input  logic [N_DRV*2-1:0]     i_val,
    input  logic [N_DRV*STR_W-1:0] i_str0,
    input  logic [N_DRV*STR_W-1:0] i_str1,
    output logic [1:0]             o_val,
    output logic [STR_W-1:0]       o_str,
    output logic                   o_undriven,
    output logic                   o_conflict
);

    logic [STR_W-1:0] w_s0;
    logic [STR_W-1:0] w_s1;
    logic [STR_W-1:0] w_sx;
    logic [STR_W-1:0] w_top;

    // A zero strength contributes nothing to the max, so it behaves like z.
    always_comb begin
        w_s0 = STR_HIGHZ;
        w_s1 = STR_HIGHZ;
        w_sx = STR_HIGHZ;
        for (int d = 0; d < N_DRV; d++) begin
            case (val_e'(i_val[d*2 +: 2]))
                V0:      w_s0 = max_str(w_s0, i_str0[d*STR_W +: STR_W]);
                V1:      w_s1 = max_str(w_s1, i_str1[d*STR_W +: STR_W]);
                VX:      w_sx = max_str(w_sx, max_str(i_str0[d*STR_W +: STR_W],
                                                      i_str1[d*STR_W +: STR_W]));
                default: ;
            endcase
        end
        w_top = max_str(max_str(w_s0, w_s1), w_sx);
    end

    always_comb begin
        o_val      = VZ;
        o_str      = STR_HIGHZ;
        o_undriven = 1'b1;
        o_conflict = 1'b0;
        if (w_top != STR_HIGHZ) begin
            o_undriven = 1'b0;
            o_str      = w_top;
            if (w_sx == w_top) begin
                o_val = VX;
            end else if (w_s0 == w_s1) begin
                o_val      = VX;
                o_conflict = 1'b1;
            end else if (w_s0 == w_top) begin
                o_val = V0;
            end else begin
                o_val = V1;
            end
        end
    end

endmodule

// File: rtl/strength_resolver_reg.sv
// Registered multi-driver net resolver with trireg-style charge retention,
// timed decay to x and a saturating equal-strength conflict counter.
module strength_resolver_reg
    import strength_pkg::*;
#(
    parameter int N_DRV        = 4,
    parameter int WIDTH        = 8,
    parameter int DECAY_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_clr_cnt,
    input  logic [N_DRV*WIDTH*2-1:0] i_drv_val,
    input  logic [N_DRV*STR_W-1:0]   i_drv_str0,
    input  logic [N_DRV*STR_W-1:0]   i_drv_str1,
    output logic [WIDTH*2-1:0]       o_res_val,
    output logic [WIDTH*STR_W-1:0]   o_res_str,
    output logic                     o_out_valid,
    output logic                     o_conflict,
    output logic [CNT_W-1:0]         o_conflict_cnt
);

    localparam int DCW = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;
    localparam logic [DCW-1:0] DECAY_LIMIT = DCW'(DECAY_CYCLES);

    logic [WIDTH*2-1:0]     r_res_val;
    logic [WIDTH*STR_W-1:0] r_res_str;
    logic                   r_out_valid;
    logic                   r_conflict;
    logic [CNT_W-1:0]       r_conflict_cnt;

    logic [WIDTH*2-1:0]     w_res_val_next;
    logic [WIDTH*STR_W-1:0] w_res_str_next;
    logic [WIDTH-1:0]       w_bit_conflict;
    logic                   w_any_conflict;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [N_DRV*2-1:0] w_codes;
            logic [1:0]         w_val;
            logic [STR_W-1:0]   w_str;
            logic               w_undriven;
            logic [1:0]         w_val_next;
            logic [STR_W-1:0]   w_str_next;
            logic [DCW-1:0]     w_decay_next;
            logic [DCW-1:0]     r_decay;

            always_comb begin
                w_codes = '0;
                for (int d = 0; d < N_DRV; d++) begin
                    w_codes[d*2 +: 2] = i_drv_val[(d*WIDTH + gi)*2 +: 2];
                end
            end

            strength_bit_resolver #(
                .N_DRV (N_DRV)
            ) u_res (
                .i_val      (w_codes),
                .i_str0     (i_drv_str0),
                .i_str1     (i_drv_str1),
                .o_val      (w_val),
                .o_str      (w_str),
                .o_undriven (w_undriven),
                .o_conflict (w_bit_conflict[gi])
            );

            // Undriven bits keep their last driven value at small strength until
            // the hold budget expires, after which they sit at x/small.
            always_comb begin
                w_val_next   = w_val;
                w_str_next   = w_str;
                w_decay_next = '0;
                if (w_undriven) begin
                    w_val_next = VZ;
                    w_str_next = STR_HIGHZ;
                    if (DECAY_CYCLES > 0) begin
                        if (r_decay == DECAY_LIMIT) begin
                            w_val_next   = VX;
                            w_str_next   = STR_SMALL;
                            w_decay_next = r_decay;
                        end else if (r_res_val[gi*2 +: 2] != VZ &&
                                     r_res_str[gi*STR_W +: STR_W] != STR_HIGHZ) begin
                            w_val_next   = r_res_val[gi*2 +: 2];
                            w_str_next   = STR_SMALL;
                            w_decay_next = r_decay + DCW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_decay <= '0;
                end else if (i_en) begin
                    r_decay <= w_decay_next;
                end
            end

            assign w_res_val_next[gi*2 +: 2]         = w_val_next;
            assign w_res_str_next[gi*STR_W +: STR_W] = w_str_next;
        end
    endgenerate

    assign w_any_conflict = |w_bit_conflict;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_val      <= '1;
            r_res_str      <= '0;
            r_out_valid    <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_out_valid <= i_en;
            r_conflict  <= i_en & w_any_conflict;
            if (i_en) begin
                r_res_val <= w_res_val_next;
                r_res_str <= w_res_str_next;
            end
            // One increment per evaluation regardless of how many bits collide.
            if (i_clr_cnt) begin
                r_conflict_cnt <= '0;
            end else if (i_en && w_any_conflict && !(&r_conflict_cnt)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign o_res_val      = r_res_val;
    assign o_res_str      = r_res_str;
    assign o_out_valid    = r_out_valid;
    assign o_conflict     = r_conflict;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_strength_resolver_reg.sv
// Scoreboard bench: two resolvers (decay 4 and decay 0) share stimulus; expected
// responses are queued per evaluation and popped by per-DUT monitors on out_valid.
module tb_strength_resolver_reg;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int CW = 2;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              clr_cnt;
    logic [N*W*2-1:0]  drv_val;
    logic [N*3-1:0]    drv_str0;
    logic [N*3-1:0]    drv_str1;

    logic [W*2-1:0]    a_val, b_val;
    logic [W*3-1:0]    a_str, b_str;
    logic              a_valid, b_valid;
    logic              a_conf, b_conf;
    logic [CW-1:0]     a_cnt, b_cnt;

    strength_resolver_reg #(.N_DRV(N), .WIDTH(W), .DECAY_CYCLES(4), .CNT_W(CW)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr_cnt(clr_cnt),
        .i_drv_val(drv_val), .i_drv_str0(drv_str0), .i_drv_str1(drv_str1),
        .o_res_val(a_val), .o_res_str(a_str), .o_out_valid(a_valid),
        .o_conflict(a_conf), .o_conflict_cnt(a_cnt)
    );

    strength_resolver_reg #(.N_DRV(N), .WIDTH(W), .DECAY_CYCLES(0), .CNT_W(CW)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr_cnt(clr_cnt),
        .i_drv_val(drv_val), .i_drv_str0(drv_str0), .i_drv_str1(drv_str1),
        .o_res_val(b_val), .o_res_str(b_str), .o_out_valid(b_valid),
        .o_conflict(b_conf), .o_conflict_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W*2-1:0] v;
        logic [W*3-1:0] s;
        logic           c;
        logic [CW-1:0]  n;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [CW-1:0] cnt_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [W*2-1:0] rv(input logic [1:0] v);
        return {W{v}};
    endfunction

    function automatic logic [W*3-1:0] rs(input logic [2:0] s);
        return {W{s}};
    endfunction

    task automatic set_drv(input int d, input logic [1:0] code,
                           input logic [2:0] s0, input logic [2:0] s1);
        for (int b = 0; b < W; b++) drv_val[(d*W + b)*2 +: 2] = code;
        drv_str0[d*3 +: 3] = s0;
        drv_str1[d*3 +: 3] = s1;
    endtask

    task automatic all_z();
        for (int d = 0; d < N; d++) set_drv(d, 2'b11, 3'd0, 3'd0);
    endtask

    // One en=1 evaluation: queue the expectation, then advance to the next negedge.
    task automatic step(input logic [W*2-1:0] va, input logic [W*3-1:0] sa,
                        input logic [W*2-1:0] vb, input logic [W*3-1:0] sb,
                        input logic c);
        en = 1'b1;
        if (c && cnt_m != '1) cnt_m = cnt_m + 1'b1;
        q_a.push_back('{v: va, s: sa, c: c, n: cnt_m});
        q_b.push_back('{v: vb, s: sb, c: c, n: cnt_m});
        @(negedge clk);
    endtask

    task automatic idle_chk(input logic [W*2-1:0] va, input logic [W*3-1:0] sa,
                            input logic [W*2-1:0] vb, input logic [W*3-1:0] sb);
        chk("a_idle_valid", 32'(a_valid), 32'd0);
        chk("b_idle_valid", 32'(b_valid), 32'd0);
        chk("a_idle_conflict", 32'(a_conf), 32'd0);
        chk("a_idle_val", 32'(a_val), 32'(va));
        chk("a_idle_str", 32'(a_str), 32'(sa));
        chk("b_idle_val", 32'(b_val), 32'(vb));
        chk("b_idle_str", 32'(b_str), 32'(sb));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && a_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_valid: got valid=1, expected no output");
            end else begin
                exp_t e;
                e = q_a.pop_front();
                $display("a txn: val=%h str=%h conflict=%0b cnt=%0d", a_val, a_str, a_conf, a_cnt);
                chk("a_res_val", 32'(a_val), 32'(e.v));
                chk("a_res_str", 32'(a_str), 32'(e.s));
                chk("a_conflict", 32'(a_conf), 32'(e.c));
                chk("a_conflict_cnt", 32'(a_cnt), 32'(e.n));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && b_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_valid: got valid=1, expected no output");
            end else begin
                exp_t e;
                e = q_b.pop_front();
                $display("b txn: val=%h str=%h conflict=%0b cnt=%0d", b_val, b_str, b_conf, b_cnt);
                chk("b_res_val", 32'(b_val), 32'(e.v));
                chk("b_res_str", 32'(b_str), 32'(e.s));
                chk("b_conflict", 32'(b_conf), 32'(e.c));
                chk("b_conflict_cnt", 32'(b_cnt), 32'(e.n));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        clr_cnt = 1'b0;
        drv_val = '0;
        drv_str0 = '0;
        drv_str1 = '0;
        cnt_m   = '0;
        all_z();
        repeat (2) @(negedge clk);
        chk("rst_a_val", 32'(a_val), 32'hFFFF);
        chk("rst_a_str", 32'(a_str), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_conflict", 32'(a_conf), 32'd0);
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_b_val", 32'(b_val), 32'hFFFF);
        rst_n = 1'b1;
        @(negedge clk);

        // Priority: x strong beats 1 pull beats 0 weak; then 1 pull wins.
        set_drv(0, 2'b00, 3'd3, 3'd3);
        set_drv(1, 2'b01, 3'd5, 3'd5);
        set_drv(2, 2'b10, 3'd6, 3'd6);
        step(rv(2'b10), rs(3'd6), rv(2'b10), rs(3'd6), 1'b0);
        set_drv(2, 2'b11, 3'd0, 3'd0);
        step(rv(2'b01), rs(3'd5), rv(2'b01), rs(3'd5), 1'b0);

        // Equal-strength conflict, counter saturation at 3, clear while en=0.
        set_drv(0, 2'b00, 3'd5, 3'd5);
        repeat (5) step(rv(2'b10), rs(3'd5), rv(2'b10), rs(3'd5), 1'b1);
        en = 1'b0;
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        cnt_m = '0;
        chk("a_cnt_cleared", 32'(a_cnt), 32'd0);
        chk("b_cnt_cleared", 32'(b_cnt), 32'd0);
        idle_chk(rv(2'b10), rs(3'd5), rv(2'b10), rs(3'd5));

        // Per-bit variation: d0 drives 0 on even bits and 1 on odd bits.
        all_z();
        for (int b = 0; b < W; b++) drv_val[b*2 +: 2] = (b % 2 == 1) ? 2'b01 : 2'b00;
        drv_str0[2:0] = 3'd6;
        drv_str1[2:0] = 3'd6;
        step(16'h4444, rs(3'd6), 16'h4444, rs(3'd6), 1'b0);

        // Charge retention: 1 strong, then z; decay-0 instance drops to z at once.
        all_z();
        set_drv(0, 2'b01, 3'd6, 3'd6);
        step(rv(2'b01), rs(3'd6), rv(2'b01), rs(3'd6), 1'b0);
        all_z();
        repeat (4) step(rv(2'b01), rs(3'd1), rv(2'b11), rs(3'd0), 1'b0);
        repeat (2) step(rv(2'b10), rs(3'd1), rv(2'b11), rs(3'd0), 1'b0);
        set_drv(0, 2'b00, 3'd3, 3'd3);
        step(rv(2'b00), rs(3'd3), rv(2'b00), rs(3'd3), 1'b0);

        // en gating freezes the hold counter mid-decay.
        set_drv(0, 2'b01, 3'd6, 3'd6);
        step(rv(2'b01), rs(3'd6), rv(2'b01), rs(3'd6), 1'b0);
        all_z();
        repeat (2) step(rv(2'b01), rs(3'd1), rv(2'b11), rs(3'd0), 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_drv(0, (i % 2 == 1) ? 2'b00 : 2'b10, 3'd6, 3'd6);
            @(negedge clk);
            idle_chk(rv(2'b01), rs(3'd1), rv(2'b11), rs(3'd0));
        end
        all_z();
        repeat (2) step(rv(2'b01), rs(3'd1), rv(2'b11), rs(3'd0), 1'b0);
        step(rv(2'b10), rs(3'd1), rv(2'b11), rs(3'd0), 1'b0);

        // Async reset during a hold discards the charge.
        set_drv(0, 2'b01, 3'd6, 3'd6);
        step(rv(2'b01), rs(3'd6), rv(2'b01), rs(3'd6), 1'b0);
        all_z();
        step(rv(2'b01), rs(3'd1), rv(2'b11), rs(3'd0), 1'b0);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a_val", 32'(a_val), 32'hFFFF);
        chk("midrst_a_str", 32'(a_str), 32'd0);
        chk("midrst_a_valid", 32'(a_valid), 32'd0);
        chk("midrst_b_val", 32'(b_val), 32'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_m = '0;
        repeat (2) step(rv(2'b11), rs(3'd0), rv(2'b11), rs(3'd0), 1'b0);

        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_pending_expectations", 32'(q_a.size()), 32'd0);
        chk("b_pending_expectations", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
